// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the external memory bus between fetch and data ports.
// Each transfer runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> ACK.
module mem_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] Data_BUS_WRITE,
    input  logic [DW-1:0] Data_BUS_READ,
    output logic          CS,
    output logic          WR,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t        state, state_nxt;
    logic          gnt_d, gnt_d_nxt;
    logic          last_d, last_d_nxt;
    logic          lat_we, lat_we_nxt;
    logic [AW-1:0] lat_addr, lat_addr_nxt;
    logic [DW-1:0] lat_wdata, lat_wdata_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          pick_d;
    logic          in_access;
    logic          sample_rd;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            last_d    <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            gnt_d     <= gnt_d_nxt;
            last_d    <= last_d_nxt;
            lat_we    <= lat_we_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // With both ports pending, D wins only if IF was served last.
    always_comb begin
        state_nxt     = state;
        gnt_d_nxt     = gnt_d;
        last_d_nxt    = last_d;
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        cnt_nxt       = cnt;
        pick_d        = d_req && (!if_req || !last_d);
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    state_nxt     = ACCESS;
                    gnt_d_nxt     = pick_d;
                    last_d_nxt    = pick_d;
                    lat_addr_nxt  = pick_d ? d_addr : if_addr;
                    lat_we_nxt    = pick_d && d_we;
                    lat_wdata_nxt = pick_d ? d_wdata : '0;
                    cnt_nxt       = CNT_INIT;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_access = (state_nxt == ACCESS);
    assign sample_rd = (state == ACCESS) && (cnt == 4'd0) && !lat_we;

    // Bus pins and acks are registered from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CS             <= 1'b0;
            WR             <= 1'b0;
            ADDR           <= '0;
            Data_BUS_WRITE <= '0;
            if_ack         <= 1'b0;
            d_ack          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            CS             <= in_access;
            WR             <= in_access && lat_we_nxt;
            ADDR           <= in_access ? lat_addr_nxt : '0;
            Data_BUS_WRITE <= (in_access && lat_we_nxt) ? lat_wdata_nxt : '0;
            if_ack         <= (state_nxt == ACK) && !gnt_d_nxt;
            d_ack          <= (state_nxt == ACK) && gnt_d_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (sample_rd) begin
            if (gnt_d) begin
                d_rdata <= Data_BUS_READ;
            end else begin
                if_rdata <= Data_BUS_READ;
            end
        end
    end

endmodule
